// File: rtl/conv_stream_layer.sv
// Streaming KxK convolution over a raster pixel stream: NUM_F parallel filters sharing
// K-1 line buffers and a KxK window, with shift/saturate/optional-ReLU on each result.
module conv_stream_layer #(
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 32,
  parameter int IMG_H      = 32,
  parameter int K          = 5,
  parameter int NUM_F      = 6,
  parameter int FRAC_BITS  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coef_we,
  input  logic [$clog2(NUM_F*K*K)-1:0]  coef_addr,
  input  logic [DATA_WIDTH-1:0]         coef_data,
  input  logic                          relu_en,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_F*DATA_WIDTH-1:0]   out_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          dbg_state
);
  localparam int DW = DATA_WIDTH;
  localparam int NC = NUM_F * K * K;
  localparam int AW = 2 * DW + $clog2(K * K);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_n;

  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic                 relu_q, out_last;
  logic signed [DW-1:0] coef    [NC];
  logic signed [DW-1:0] lb      [K-1][IMG_W];
  logic signed [DW-1:0] win     [K][K];
  logic signed [DW-1:0] win_n   [K][K];
  logic signed [DW-1:0] col_vec [K];
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   acc, sh;
  logic [DW-1:0]          sat;
  logic [NUM_F*DW-1:0]    res;
  logic accept, first_pix, last_col, last_row, win_done, out_hs, final_hs;

  // Both streams use valid/ready: a beat transfers on a rising edge where valid and ready
  // are both 1; a held output beat keeps out_valid/out_data frozen until it transfers.
  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign first_pix = accept && (row == '0) && (col == '0);
  assign last_col  = (col == CW'(IMG_W - 1));
  assign last_row  = (row == RW'(IMG_H - 1));
  assign win_done  = accept && (row >= RW'(K - 1)) && (col >= CW'(K - 1));
  assign out_hs    = out_valid && out_ready;
  assign final_hs  = out_hs && out_last;
  assign busy      = (state == RUN);
  assign dbg_state = state;

  // Column entering the window: ky = 0 is the oldest row, ky = K-1 the incoming pixel.
  always_comb begin
    col_vec[K-1] = in_data;
    for (int i = 0; i < K - 1; i++) col_vec[K-2-i] = lb[i][col];
    for (int ky = 0; ky < K; ky++) begin
      for (int kx = 0; kx < K - 1; kx++) win_n[ky][kx] = win[ky][kx+1];
      win_n[ky][K-1] = col_vec[ky];
    end
  end

  always_comb begin
    res  = '0;
    acc  = '0;
    prod = '0;
    sh   = '0;
    sat  = '0;
    for (int f = 0; f < NUM_F; f++) begin
      acc = '0;
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          prod = win_n[ky][kx] * coef[f*K*K + ky*K + kx];
          acc  = acc + {{(AW-2*DW){prod[2*DW-1]}}, prod};
        end
      end
      sh = acc >>> FRAC_BITS;
      if (!sh[AW-1] && (|sh[AW-2:DW-1]))      sat = {1'b0, {(DW-1){1'b1}}};
      else if (sh[AW-1] && !(&sh[AW-2:DW-1])) sat = {1'b1, {(DW-1){1'b0}}};
      else                                    sat = sh[DW-1:0];
      if (relu_q && sat[DW-1]) sat = '0;
      res[f*DW +: DW] = sat;
    end
  end

  // A new frame's first pixel on the final-handshake edge keeps the block running.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (final_hs && !first_pix) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      relu_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      frame_done <= final_hs;
      if (first_pix) relu_q <= relu_en;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (win_done) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_last  <= last_row && last_col;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Storage without reset: coefficients survive reset, stale buffer rows are never emitted.
  always_ff @(posedge clk) begin
    if (coef_we && !busy && (int'(coef_addr) < NC)) coef[coef_addr] <= coef_data;
    if (accept) begin
      lb[0][col] <= in_data;
      for (int i = 1; i < K - 1; i++) lb[i][col] <= lb[i-1][col];
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++) win[ky][kx] <= win_n[ky][kx];
    end
  end
endmodule
